// File: rtl/lag_pl_output_arbiter_if.sv
// rtl/lag_pl_output_arbiter_if.sv - FIFO-head and output-stage bundle of the PL output arbiter
//
// Purpose: carries the FIFO-bank side (heads, pop, returned credits) and the
// registered output stage of lag_pl_output_arbiter.
// Signals:
//   head_data  [n*flit_w] head flit per FIFO, slice i = channel i
//   head_empty [n]        FIFO empty flags
//   head_tail  [n]        head flit is a packet tail
//   credit_in  [n]        one pulse returns one downstream credit
//   pop        [n]        one-hot/zero pop vector back to the FIFO bank
//   out_valid/out_data/out_pl/out_tail  registered selected flit
// Modports: master = arbiter, slave = FIFO bank / downstream environment.

interface lag_pl_output_arbiter_if #(
  parameter int n      = 4,
  parameter int flit_w = 64
);
  localparam int pl_w = (n > 1) ? $clog2(n) : 1;

  logic [n*flit_w-1:0] head_data;
  logic [n-1:0]        head_empty;
  logic [n-1:0]        head_tail;
  logic [n-1:0]        credit_in;
  logic [n-1:0]        pop;
  logic                out_valid;
  logic [flit_w-1:0]   out_data;
  logic [pl_w-1:0]     out_pl;
  logic                out_tail;

  modport master (
    input  head_data, head_empty, head_tail, credit_in,
    output pop, out_valid, out_data, out_pl, out_tail
  );

  modport slave (
    output head_data, head_empty, head_tail, credit_in,
    input  pop, out_valid, out_data, out_pl, out_tail
  );
endinterface

// File: rtl/lag_pl_output_arbiter.sv
// rtl/lag_pl_output_arbiter.sv - round-robin, credit-gated, wormhole-locking PL output arbiter
//
// Purpose: picks at most one FIFO head per cycle (round-robin from ptr),
// requires a downstream credit, keeps a channel locked until its tail flit
// is sent, and registers the chosen flit into the output stage.
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   bus         lag_pl_output_arbiter_if.master (heads, pop, credits, output stage)
//   credit_err  sticky: a credit was returned to an already-full counter

module lag_pl_output_arbiter #(
  parameter int n       = 4,
  parameter int flit_w  = 64,
  parameter int credits = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  lag_pl_output_arbiter_if.master        bus,
  output logic                           credit_err
);
  localparam int pl_w  = (n > 1) ? $clog2(n) : 1;
  localparam int cnt_w = $clog2(credits + 1);

  logic [cnt_w-1:0] cnt [n];
  logic [pl_w-1:0]  ptr;
  logic             lock_valid;
  logic [pl_w-1:0]  lock_id;

  logic [n-1:0]     elig;
  logic             grant_valid;
  logic [pl_w-1:0]  grant_id;
  logic [n-1:0]     pop_vec;

  // While locked, every channel except the lock owner is masked.
  always_comb begin
    elig = '0;
    for (int i = 0; i < n; i++) begin
      elig[i] = !bus.head_empty[i] && (cnt[i] != '0) &&
                (!lock_valid || (lock_id == pl_w'(i)));
    end
  end

  // First eligible channel scanning ptr, ptr+1, ... modulo n.
  always_comb begin
    int              idx;
    logic [pl_w-1:0] cand;
    grant_valid = 1'b0;
    grant_id    = '0;
    idx         = 0;
    cand        = '0;
    for (int k = 0; k < n; k++) begin
      idx = int'(ptr) + k;
      if (idx >= n) idx = idx - n;
      cand = pl_w'(idx);
      if (!grant_valid && elig[cand]) begin
        grant_valid = 1'b1;
        grant_id    = cand;
      end
    end
  end

  always_comb begin
    pop_vec = '0;
    if (grant_valid) pop_vec[grant_id] = 1'b1;
  end

  // Reset level gates pop directly so nothing is popped during reset.
  assign bus.pop = rst_n ? pop_vec : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < n; i++) cnt[i] <= cnt_w'(credits);
      ptr           <= '0;
      lock_valid    <= 1'b0;
      lock_id       <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_pl    <= '0;
      bus.out_tail  <= 1'b0;
      credit_err    <= 1'b0;
    end else begin
      if (grant_valid) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= bus.head_data[int'(grant_id) * flit_w +: flit_w];
        bus.out_pl    <= grant_id;
        bus.out_tail  <= bus.head_tail[grant_id];
        ptr           <= (grant_id == pl_w'(n - 1)) ? '0 : grant_id + pl_w'(1);
        if (bus.head_tail[grant_id]) begin
          lock_valid <= 1'b0;
        end else begin
          lock_valid <= 1'b1;
          lock_id    <= grant_id;
        end
      end else begin
        bus.out_valid <= 1'b0;
      end

      // A grant and a returned credit on the same channel cancel out.
      for (int i = 0; i < n; i++) begin
        if (bus.credit_in[i] && !pop_vec[i]) begin
          if (cnt[i] == cnt_w'(credits)) credit_err <= 1'b1;
          else                            cnt[i] <= cnt[i] + cnt_w'(1);
        end else if (pop_vec[i] && !bus.credit_in[i]) begin
          cnt[i] <= cnt[i] - cnt_w'(1);
        end
      end
    end
  end
endmodule

// File: doc/lag_pl_output_arbiter.md
Name: lag_pl_output_arbiter

Overview:
- Downstream neighbour of the physical-channel FIFO bank. It consumes the heads of n parallel PL FIFOs and issues the per-FIFO pop vector back to that bank.
- Each cycle it selects at most one flit with a round-robin policy. Selection requires a downstream credit and respects wormhole packet locking.
- The selected flit goes into a registered output stage.
- It keeps one credit counter per physical channel, tracking free slots in the next hop's buffer.

Parameters:
- n, 4, number of physical channels / FIFOs arbitrated.
- flit_w, 64, width of one flit payload.
- credits, 3, downstream buffer depth per channel; also the credit counter reset value. Legal range 1..15.

Ports:
- clk  input  1  clock; all state is updated on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- head_data  input  n*flit_w  head flit of each FIFO; slice i belongs to channel i.
- head_empty  input  n  FIFO i empty flag, taken from the FIFO flags.
- head_tail  input  n  head flit of FIFO i is a packet tail.
- pop  output  n  one-hot or zero; pops FIFO i at this clock edge.
- credit_in  input  n  one pulse returns one credit to channel i.
- out_valid  output  1  registered; a flit is presented this cycle.
- out_data  output  flit_w  registered flit payload.
- out_pl  output  clog2(n)  registered binary channel id of out_data.
- out_tail  output  1  registered tail bit of out_data.
- credit_err  output  1  sticky; a credit was returned to a full counter.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - cnt[i]=credits, ptr=0, lock_valid=0, lock_id=0.
  - out_valid=0, out_data=0, out_pl=0, out_tail=0, credit_err=0.
  - pop=0 while rst_n=0, overriding the eligibility logic.
  - Reset in mid-packet discards the lock and any pending grant; nothing is popped in that cycle.
- Eligibility: elig[i] = !head_empty[i] && cnt[i]!=0.
  - If lock_valid=1, only i==lock_id may be eligible; every other channel is masked.
- Arbitration is combinational, within the same cycle:
  - The grant is the first eligible i scanning ptr, ptr+1, ..., wrapping modulo n.
  - pop = onehot(grant), or 0 if nothing is eligible.
- On a grant g at the clock edge:
  - out_valid<=1, out_data<=head_data[g], out_pl<=g, out_tail<=head_tail[g]. Latency is one cycle from pop to out_valid.
  - ptr <= (g+1) mod n.
  - If head_tail[g]=0: lock_valid<=1, lock_id<=g. If head_tail[g]=1: lock_valid<=0.
  - cnt[g] is decremented.
- With no grant: out_valid<=0. out_data, out_pl and out_tail hold their values. ptr and the lock are unchanged.
- A locked channel that is empty or has no credit causes a stall: no grant and no pop. The lock persists until that channel's tail flit is sent.
- Credit update for each i, applied at the edge:
  - grant-to-i and credit_in[i] together: cnt unchanged.
  - credit_in[i] only: cnt+1. If cnt==credits, cnt stays at credits and credit_err<=1.
  - grant-to-i only: cnt-1. A grant never happens at cnt=0 because of the eligibility rule.
- credit_err clears only on reset.
- Throughput: at most one flit per cycle. A single channel with unlimited credit and data can sustain one flit per cycle.
- No combinational path from credit_in to pop; credits take effect from the next cycle.

Test Plan:
- Reset then idle: all head_empty=1 -> pop=0, out_valid=0. No credits returned -> cnt all 3, credit_err=0.
- Fairness: all 4 FIFOs non-empty, single-flit packets (tail=1), credit_in[i] asserted on the cycle each channel is granted. Expected:
  - Grants are 0,1,2,3,0,...
  - out_pl trails pop by one cycle.
  - Each out_data equals the head_data slice that was popped.
- Wormhole lock: ch1 sends a 3-flit packet (tail on the third flit) while ch0, ch2 and ch3 are non-empty.
  - ch1 is granted three consecutive cycles and no other pop occurs.
  - The next grant is ch2.
- Credit exhaustion: ch0 non-empty, no credit_in, credits=3.
  - Exactly 3 pops, then pop[0]=0.
  - One credit_in[0] pulse -> one more pop on the following cycle.
- Simultaneous grant and credit on ch2 at cnt=1 -> cnt stays 1 and ch2 stays eligible. Extra credit_in[2] at cnt=3 -> cnt stays 3 and credit_err=1 sticky.
- Async reset mid-packet (lock_valid=1 on ch3) -> outputs and pop=0 immediately. After release, arbitration restarts at ch0 with no lock.
